// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Used by fetch_unit and fetch_fifo.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        IDLE = 2'd2
    } fetch_state_t;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_INC  = 4;
    localparam int unsigned PC_W    = 64;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Response buffer for the fetch stage: DEPTH-entry FIFO with push, pop and flush.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int unsigned W      = 96,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [W-1:0] o_rdata,
    output logic         o_empty,
    output logic         o_full,
    output logic [AW:0]  o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    // Storage needs no reset: the head is only consumed while the count is non-zero.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, in-order imem requests, response buffer, redirect/flush.
// Define FETCH_PERF_EN to add the perf_fetched / perf_dropped counters. N must not exceed PC_W.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned  N        = 64,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int unsigned  DEPTH    = 2
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_fetch_en,
    output logic               o_imem_req,
    output logic [N-1:0]       o_imem_addr,
    input  logic               i_imem_gnt,
    input  logic               i_imem_rvalid,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    input  logic               i_redirect,
    input  logic [N-1:0]       i_redirect_pc,
    output logic               o_if_valid,
    input  logic               i_if_ready,
    output logic [N-1:0]       o_if_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]        o_perf_fetched,
    output logic [31:0]        o_perf_dropped,
`endif
    output logic [INSTR_W-1:0] o_if_instr
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [N-1:0]       r_pc;
    logic [N-1:0]       r_resp_pc;
    logic [CW-1:0]      r_inflight;
    logic [CW-1:0]      r_drop;
    logic [N-1:0]       r_hold_pc;
    logic [INSTR_W-1:0] r_hold_instr;

    logic [CW-1:0]      w_count;
    logic [CW:0]        w_credit_used;
    logic               w_credit_ok;
    logic               w_req;
    logic               w_fire;
    logic               w_discard;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;
    logic [N-1:0]       w_target;
    fetch_entry_t       w_wentry;
    fetch_entry_t       w_head;

    assign w_target = i_redirect_pc & ~N'(PC_INC - 1);

    // Responses still owed by memory count against buffer space, so a push never overflows.
    assign w_credit_used = {1'b0, r_inflight} + {1'b0, w_count};
    assign w_credit_ok   = w_credit_used < (CW+1)'(DEPTH);

    assign w_fire    = w_req & i_imem_gnt;
    assign w_discard = i_imem_rvalid & (r_drop != '0);
    assign w_push    = i_imem_rvalid & (r_drop == '0) & ~i_redirect;
    assign w_pop     = ~w_empty & i_if_ready & ~i_redirect;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= BOOT;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            BOOT:    w_state_next = i_fetch_en ? RUN : IDLE;
            RUN:     if (!i_fetch_en) w_state_next = IDLE;
            IDLE:    if (i_fetch_en) w_state_next = RUN;
            default: w_state_next = BOOT;
        endcase
    end

    always_comb begin
        w_req = 1'b0;
        if (r_state == RUN) w_req = w_credit_ok & ~i_redirect;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pc       <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_inflight <= r_inflight + CW'(w_fire) - CW'(i_imem_rvalid);
            if (i_redirect) begin
                r_pc      <= w_target;
                r_resp_pc <= w_target;
                // Everything still in flight belongs to the abandoned path.
                r_drop    <= r_inflight - CW'(i_imem_rvalid);
            end else begin
                if (w_fire)    r_pc      <= r_pc + N'(PC_INC);
                if (w_push)    r_resp_pc <= r_resp_pc + N'(PC_INC);
                if (w_discard) r_drop    <= r_drop - CW'(1);
            end
        end
    end

    assign w_wentry.pc    = PC_W'(r_resp_pc);
    assign w_wentry.instr = i_imem_rdata;

    fetch_fifo #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_wdata (w_wentry),
        .i_pop   (w_pop),
        .i_flush (i_redirect),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_count (w_count)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_hold_pc    <= '0;
            r_hold_instr <= '0;
        end else if (!w_empty) begin
            r_hold_pc    <= N'(w_head.pc);
            r_hold_instr <= w_head.instr;
        end
    end

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_pc;
    assign o_if_valid  = ~w_empty;
    assign o_if_pc     = w_empty ? r_hold_pc : N'(w_head.pc);
    assign o_if_instr  = w_empty ? r_hold_instr : w_head.instr;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_dropped;
    logic [31:0] w_drop_inc;

    assign w_drop_inc = i_redirect ? 32'(w_count) + 32'(i_imem_rvalid) : 32'(w_discard);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_perf_fetched <= '0;
            r_perf_dropped <= '0;
        end else begin
            r_perf_fetched <= sat_add32(r_perf_fetched, 32'(w_pop));
            r_perf_dropped <= sat_add32(r_perf_dropped, w_drop_inc);
        end
    end

    assign o_perf_fetched = r_perf_fetched;
    assign o_perf_dropped = r_perf_dropped;
`endif

    a_rvalid_owed: assert property (@(posedge i_clk) disable iff (!i_reset)
        i_imem_rvalid |-> (r_inflight != '0));

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset)
        w_push |-> (!w_full || w_pop));

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the pipeline: holds the PC and issues in-order instruction-memory requests.
- Buffers returned instructions and presents {pc, instr} to the IF/ID pipeline register (a flopr instance) through a valid/ready handshake.
- Supports branch redirect with flush, and fetch enable/disable.
- Sits directly upstream of the IF/ID flopr; drives its d input.

Parameters:
- N, 64, PC/address width
- RESET_PC, 64'h0, first fetch address after reset
- DEPTH, 2, response-buffer entries; also the maximum requests in flight (power of 2, ≥2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- fetch_en  in  1  permit new requests
- imem_req  out  1  request valid
- imem_addr  out  N  request address (word-aligned)
- imem_gnt  in  1  request accepted this cycle when imem_req=1
- imem_rvalid  in  1  response valid; responses return in order, ≥1 cycle after grant
- imem_rdata  in  32  response instruction
- redirect  in  1  branch/exception redirect
- redirect_pc  in  N  redirect target
- if_valid  out  1  {if_pc, if_instr} valid
- if_ready  in  1  downstream accepts
- if_pc  out  N  PC of presented instruction
- if_instr  out  32  presented instruction

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0
  - internal: state=BOOT, buffer empty, inflight=0, drop=0
- FSM states:
  - BOOT: exactly one cycle after reset release → RUN if fetch_en, else IDLE.
  - RUN → IDLE when fetch_en=0.
  - IDLE → RUN when fetch_en=1.
  - redirect does not change state.
- Request issue (combinational):
  - imem_req=1 only in RUN, when inflight+occupancy < DEPTH and redirect=0.
  - imem_addr = pc.
  - On imem_req & imem_gnt: pc ← pc+4 (mod 2^N, wraps silently), inflight+1.
- Response:
  - On imem_rvalid: inflight−1.
  - If drop>0: discard the response and decrement drop.
  - Otherwise push {resp_pc, imem_rdata}. resp_pc is a second counter advancing +4 per kept push.
  - The credit rule guarantees no push to a full buffer; an rvalid with inflight=0 is a protocol error (assertion).
- Output:
  - if_valid = buffer non-empty; if_pc/if_instr = head entry.
  - Pop on if_valid & if_ready.
  - Push and pop in the same cycle keep occupancy unchanged.
  - Empty buffer: if_pc/if_instr hold their last values.
- Redirect (sampled at clock edge, highest priority):
  - pc ← {redirect_pc[N-1:2],2'b00}; resp_pc ← same value.
  - Buffer flushed; drop ← inflight − (rvalid this cycle ? 1 : 0); a same-cycle response is dropped.
  - Same-cycle pop is ignored and imem_req is forced 0 that cycle.
  - First post-redirect request issues the next cycle.
- Latency: grant at cycle t, rvalid at t+k → if_valid at t+k+1.
- fetch_en=0 mid-stream: no new requests; in-flight responses are still accepted and delivered.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - adds outputs perf_fetched (32) and perf_dropped (32).
  - perf_fetched counts pops; perf_dropped counts discarded responses plus flushed buffer entries.
  - Both saturate at 2^32−1 and reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- fetch_pkg holds:
  - fetch_state_t enum {BOOT, RUN, IDLE}
  - INSTR_W=32
  - PC_INC=4
  - fetch_entry_t struct {pc, instr} (N-parameterized via localparam default 64)
- Sub-module fetch_fifo: DEPTH entries with push, pop, flush, empty, full and count outputs; async active-low reset.

Test Plan:
- Reset release, fetch_en=1, imem_gnt=1, 1-cycle rvalid returning rdata=addr>>2, if_ready=1 → requests at 0,4,8,…; if_pc=0,4,8 with if_instr=0,1,2 in order.
- if_ready=0 for 10 cycles → at most 2 outstanding+buffered; imem_req drops to 0; no instruction lost after if_ready=1.
- redirect with redirect_pc=0x103 while 2 requests are in flight → both responses dropped; next imem_addr=0x100; first if_pc=0x100.
- imem_gnt stalled 5 cycles → imem_addr held at 0x8; pc does not advance.
- reset=0 asserted mid-stream with if_valid=1 → if_valid=0 immediately (asynchronous); restart at RESET_PC.
- With FETCH_PERF_EN: 6 pops plus a redirect discarding 2 responses → perf_fetched=6, perf_dropped=2.
